// File: rtl/mel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mel_pkg
// Description : Shared types and defaults for the mel filterbank arbiter.
//               Holds the arbiter state encoding, default filterbank sizing
//               and the power sample type.
// Revision    : 1.0 - initial release
// ============================================================================
package mel_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_RESULT = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_FILTERS = 40;
  localparam int DEFAULT_MAX_BINS    = 257;

  typedef logic [31:0] power_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. It returns the first
//               requester found searching upward from i_last_grant+1, with
//               wrap-around modulo NUM_REQ.
// Ports       : i_req        - request vector
//               i_last_grant - most recently granted index (lowest priority)
//               o_grant      - selected index (0 when nothing requests)
//               o_any_req    - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last_grant,
  output logic [IW-1:0]      o_grant,
  output logic               o_any_req
);

  logic [IW-1:0] w_idx;

  // Scan from lowest to highest priority; the last hit written is the
  // nearest requester after i_last_grant, which is the round-robin winner.
  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(i_last_grant) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_grant   = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mel_filterbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mel_filterbank_arbiter
// Description : Shares one mel filterbank between NUM_CHANNELS power-spectrum
//               streams. A whole frame is granted at a time (round robin),
//               the grant is held until the filterbank result has been
//               handed downstream, and the result is tagged with its channel.
// Ports       : clk_in / rst_in          - clock, async active-high reset
//               power_*_in / _ready_out   - per-channel frame streams
//               fb_*_out / fb_ready_in    - beat stream into the filterbank
//               fb_filtered_*             - filterbank energy vector
//               filtered_*                - tagged energy vector downstream
//               overrun_out               - sticky, a frame hit MAX_BINS
// Revision    : 1.0 - initial release
// ============================================================================
module mel_filterbank_arbiter
  import mel_pkg::*;
#(
  parameter  int NUM_CHANNELS = 2,
  parameter  int NUM_FILTERS  = DEFAULT_NUM_FILTERS,
  parameter  int MAX_BINS     = DEFAULT_MAX_BINS,
  localparam int CHW          = $clog2(NUM_CHANNELS)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_CHANNELS-1:0][31:0]     power_data_in,
  input  logic [NUM_CHANNELS-1:0]           power_valid_in,
  input  logic [NUM_CHANNELS-1:0]           power_last_in,
  output logic [NUM_CHANNELS-1:0]           power_ready_out,
  output logic [31:0]                       fb_data_out,
  output logic                              fb_valid_out,
  output logic                              fb_last_out,
  input  logic                              fb_ready_in,
  input  logic [NUM_FILTERS-1:0][31:0]      fb_filtered_data_in,
  input  logic                              fb_filtered_valid_in,
  output logic                              fb_filtered_ready_out,
  output logic [NUM_FILTERS-1:0][31:0]      filtered_data_out,
  output logic [CHW-1:0]                    filtered_chan_out,
  output logic                              filtered_valid_out,
  input  logic                              filtered_ready_in,
  output logic                              overrun_out
);

  localparam int CW = (MAX_BINS > 1) ? $clog2(MAX_BINS) : 1;

  state_t         r_state;
  state_t         w_next_state;
  logic [CHW-1:0] r_grant;
  logic [CHW-1:0] r_last_grant;
  logic [CW-1:0]  r_bin_cnt;
  logic           r_overrun;

  logic [CHW-1:0] w_arb_grant;
  logic           w_any_req;
  logic           w_at_limit;
  logic           w_last;
  logic           w_xfer;

  rr_arbiter #(
    .NUM_REQ (NUM_CHANNELS)
  ) u_rr_arbiter (
    .i_req        (power_valid_in),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_any_req    (w_any_req)
  );

  // A frame is cut at MAX_BINS beats even without the source's last flag.
  assign w_at_limit = (r_bin_cnt == CW'(MAX_BINS - 1));
  assign w_last     = power_last_in[r_grant] | w_at_limit;
  assign w_xfer     = (r_state == STREAM) && power_valid_in[r_grant] && fb_ready_in;

  assign filtered_data_out = fb_filtered_data_in;
  assign filtered_chan_out = r_grant;
  assign overrun_out       = r_overrun;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state          = r_state;
    power_ready_out       = '0;
    fb_data_out           = '0;
    fb_valid_out          = 1'b0;
    fb_last_out           = 1'b0;
    fb_filtered_ready_out = 1'b0;
    filtered_valid_out    = 1'b0;
    case (r_state)
      IDLE: begin
        // Arbitration bubble: the winner is registered, no beat is taken.
        if (w_any_req) begin
          w_next_state = STREAM;
        end
      end
      STREAM: begin
        fb_data_out              = power_data_in[r_grant];
        fb_valid_out             = power_valid_in[r_grant];
        fb_last_out              = w_last;
        power_ready_out[r_grant] = fb_ready_in;
        if (w_xfer && w_last) begin
          w_next_state = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        filtered_valid_out    = fb_filtered_valid_in;
        fb_filtered_ready_out = filtered_ready_in;
        if (fb_filtered_valid_in && filtered_ready_in) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_grant      <= '0;
      r_last_grant <= CHW'(NUM_CHANNELS - 1);
      r_bin_cnt    <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        r_grant      <= w_arb_grant;
        r_last_grant <= w_arb_grant;
      end
      if (w_xfer) begin
        if (w_last) begin
          r_bin_cnt <= '0;
          // A cut without the source's own last flag means the frame was
          // too long; its remaining beats will arrive as a fresh frame.
          if (!power_last_in[r_grant]) begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_bin_cnt <= r_bin_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mel_filterbank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mel_filterbank_arbiter
// Description : Self-checking bench for mel_filterbank_arbiter: reset,
//               cycle vector table, directed frame sequences and a
//               randomized two-channel run against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mel_filterbank_arbiter;

  localparam int NCH = 2;
  localparam int NF  = 40;
  localparam int MB  = 257;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0001;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [NCH-1:0][31:0]   power_data_in;
  logic [NCH-1:0]         power_valid_in;
  logic [NCH-1:0]         power_last_in;
  logic [NCH-1:0]         power_ready_out;
  logic [31:0]            fb_data_out;
  logic                   fb_valid_out;
  logic                   fb_last_out;
  logic                   fb_ready_in;
  logic [NF-1:0][31:0]    fb_filtered_data_in;
  logic                   fb_filtered_valid_in;
  logic                   fb_filtered_ready_out;
  logic [NF-1:0][31:0]    filtered_data_out;
  logic [0:0]             filtered_chan_out;
  logic                   filtered_valid_out;
  logic                   filtered_ready_in;
  logic                   overrun_out;

  mel_filterbank_arbiter #(
    .NUM_CHANNELS (NCH),
    .NUM_FILTERS  (NF),
    .MAX_BINS     (MB)
  ) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .power_data_in         (power_data_in),
    .power_valid_in        (power_valid_in),
    .power_last_in         (power_last_in),
    .power_ready_out       (power_ready_out),
    .fb_data_out           (fb_data_out),
    .fb_valid_out          (fb_valid_out),
    .fb_last_out           (fb_last_out),
    .fb_ready_in           (fb_ready_in),
    .fb_filtered_data_in   (fb_filtered_data_in),
    .fb_filtered_valid_in  (fb_filtered_valid_in),
    .fb_filtered_ready_out (fb_filtered_ready_out),
    .filtered_data_out     (filtered_data_out),
    .filtered_chan_out     (filtered_chan_out),
    .filtered_valid_out    (filtered_valid_out),
    .filtered_ready_in     (filtered_ready_in),
    .overrun_out           (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    power_data_in        = '0;
    power_valid_in       = '0;
    power_last_in        = '0;
    fb_ready_in          = 1'b0;
    fb_filtered_data_in  = '0;
    fb_filtered_valid_in = 1'b0;
    filtered_ready_in    = 1'b0;
  endtask

  // Every step starts at a negedge: drive, settle 1ns, sample, next negedge.
  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Streams one frame from channel ch with optional ready toggling, a
  // 10-cycle valid gap after beat gap_at, and a competing request on the
  // other channel. Returns beats moved, beat number carrying fb_last, and
  // the number of protocol violations seen.
  task automatic stream_frame(input int ch, input int nbeats, input bit with_last,
                              input bit toggle, input int gap_at, input bit rival,
                              output int got, output int last_at, output int bad);
    int          gap;
    bit          holding;
    logic [31:0] held;
    got = 0; last_at = 0; bad = 0; gap = 0; holding = 0; held = '0;
    for (int cyc = 0; cyc < nbeats * 3 + 40; cyc++) begin
      power_valid_in = '0;
      power_last_in  = '0;
      if (rival) power_valid_in[1-ch] = 1'b1;
      if (gap_at != 0 && got == gap_at && gap < 10) begin
        gap++;
      end else if (got < nbeats) begin
        power_valid_in[ch] = 1'b1;
        power_data_in[ch]  = (32'(ch) << 28) | 32'(got + 1);
        power_last_in[ch]  = with_last && (got == nbeats - 1);
      end
      fb_ready_in = toggle ? ~cyc[0] : 1'b1;
      #1;
      if (rival && power_ready_out[1-ch]) bad++;
      if (fb_valid_out && filtered_chan_out != 1'(ch)) bad++;
      if (holding && fb_data_out !== held) bad++;
      holding = 1'b0;
      if (fb_valid_out && !fb_ready_in) begin
        holding = 1'b1;
        held    = fb_data_out;
      end
      if (fb_valid_out && fb_ready_in) begin
        got++;
        if (fb_last_out) last_at = got;
      end
      @(negedge clk_in);
      if (last_at != 0 || got >= nbeats) break;
    end
    power_valid_in = '0;
    power_last_in  = '0;
    fb_ready_in    = 1'b0;
  endtask

  // Presents a filterbank result (word i = val+i), holds downstream ready low
  // for hold cycles, then waits (bounded) for the pass-through handshake.
  task automatic deliver_result(input logic [31:0] val, input int hold,
                                output int chan, output int bad);
    bit done;
    bad = 0; chan = -1; done = 0;
    fb_filtered_valid_in = 1'b1;
    for (int i = 0; i < NF; i++) fb_filtered_data_in[i] = val + 32'(i);
    filtered_ready_in = 1'b0;
    for (int c = 0; c < hold; c++) begin
      #1;
      if (!filtered_valid_out || fb_filtered_ready_out) bad++;
      if (filtered_data_out[NF-1] !== val + 32'(NF - 1)) bad++;
      @(negedge clk_in);
    end
    filtered_ready_in = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (filtered_valid_out && fb_filtered_ready_out) begin
        chan = int'(filtered_chan_out);
        done = 1'b1;
        if (filtered_data_out[0] !== val) bad++;
      end
      @(negedge clk_in);
    end
    fb_filtered_valid_in = 1'b0;
    filtered_ready_in    = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  pv, pl;
    logic        fr, fv, frr;
    logic [1:0]  e_pr;
    logic        e_fbv, e_fbl, e_fdv, e_fbfr, e_chan;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[13];

  // Random-phase model state
  int          flen[2][6];
  int          fi[2], bi[2];
  logic [31:0] exp_beats[$];
  bit          exp_last[$];
  int          exp_chan[$];
  logic [31:0] exp_sum[$];

  initial begin
    int          got, last_at, bad, chan, results_seen, res_delay;
    bit          res_pend;
    logic [31:0] acc, res_val, s, d;

    // ---------------- reset: outputs low even with inputs active ----------
    idle_inputs();
    rst_in = 1'b1;
    power_valid_in = '1; power_last_in = '1; fb_ready_in = 1'b1;
    fb_filtered_valid_in = 1'b1; filtered_ready_in = 1'b1;
    power_data_in[0] = D0;
    fb_filtered_data_in[NF-1] = 32'hBEEF;
    repeat (2) @(negedge clk_in);
    #1;
    check("reset_ctrl", {power_ready_out, fb_valid_out, fb_last_out, filtered_valid_out,
                         fb_filtered_ready_out, overrun_out, filtered_chan_out}, 64'd0);
    check("reset_fb_data", fb_data_out, 64'd0);
    check("reset_passthru", filtered_data_out[NF-1], 64'hBEEF);
    @(negedge clk_in);

    // ---------------- cycle vector table ----------------------------------
    //            pv     pl     fr    fv    frr   | pr    fbv   fbl   fdv   fbfr  chan  data
    tbl[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, D0};
    tbl[2]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, D0};
    tbl[3]  = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, D0};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, D1};
    tbl[8]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[10] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D1};
    tbl[12] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D1};

    do_reset();
    power_data_in[0] = D0;
    power_data_in[1] = D1;
    for (int i = 0; i < 13; i++) begin
      power_valid_in       = tbl[i].pv;
      power_last_in        = tbl[i].pl;
      fb_ready_in          = tbl[i].fr;
      fb_filtered_valid_in = tbl[i].fv;
      filtered_ready_in    = tbl[i].frr;
      #1;
      check($sformatf("vec%0d", i),
            {power_ready_out, fb_valid_out, fb_last_out, filtered_valid_out,
             fb_filtered_ready_out, filtered_chan_out, fb_data_out},
            {tbl[i].e_pr, tbl[i].e_fbv, tbl[i].e_fbl, tbl[i].e_fdv,
             tbl[i].e_fbfr, tbl[i].e_chan, tbl[i].e_data});
      @(negedge clk_in);
    end

    // ---------------- single channel, full-length frame -------------------
    do_reset();
    stream_frame(0, 257, 1'b1, 1'b0, 0, 1'b0, got, last_at, bad);
    check("single_beats", got, 257);
    check("single_last_at", last_at, 257);
    deliver_result(32'd5, 0, chan, bad);
    check("single_chan", chan, 0);
    check("single_result_bad", bad, 0);
    check("single_overrun", overrun_out, 0);

    // ---------------- backpressure on both sides --------------------------
    stream_frame(0, 20, 1'b1, 1'b1, 0, 1'b0, got, last_at, bad);
    check("bp_beats", got, 20);
    check("bp_stable", bad, 0);
    deliver_result(32'h100, 20, chan, bad);
    check("bp_hold20", bad, 0);
    check("bp_chan", chan, 0);
    power_valid_in[1] = 1'b1; power_data_in[1] = D1; fb_ready_in = 1'b1;
    #1;
    check("bp_bubble", {fb_valid_out, power_ready_out}, 64'd0);
    @(negedge clk_in); #1;
    check("bp_next_grant", {fb_valid_out, filtered_chan_out}, {1'b1, 1'b1});
    @(negedge clk_in);

    // ---------------- mid-frame stall with a competing channel ------------
    do_reset();
    stream_frame(0, 120, 1'b1, 1'b0, 100, 1'b1, got, last_at, bad);
    check("stall_beats", got, 120);
    check("stall_rival_blocked", bad, 0);
    deliver_result(32'h200, 0, chan, bad);
    check("stall_chan", chan, 0);
    stream_frame(1, 3, 1'b1, 1'b0, 0, 1'b0, got, last_at, bad);
    check("stall_next_beats", got, 3);
    deliver_result(32'h300, 0, chan, bad);
    check("stall_next_chan", chan, 1);

    // ---------------- overrun ----------------------------------------------
    do_reset();
    stream_frame(1, 300, 1'b0, 1'b0, 0, 1'b0, got, last_at, bad);
    check("ovr_cut_beats", got, 257);
    check("ovr_last_at", last_at, 257);
    check("ovr_flag", overrun_out, 1);
    deliver_result(32'h400, 0, chan, bad);
    check("ovr_chan", chan, 1);
    stream_frame(1, 43, 1'b0, 1'b0, 0, 1'b0, got, last_at, bad);
    check("ovr_rest_beats", got, 43);
    check("ovr_rest_nolast", last_at, 0);
    check("ovr_sticky", overrun_out, 1);

    // ---------------- asynchronous reset mid-frame ------------------------
    do_reset();
    check("rst_clears_overrun", overrun_out, 0);
    stream_frame(0, 50, 1'b0, 1'b0, 0, 1'b0, got, last_at, bad);
    check("rst_pre_beats", got, 50);
    power_valid_in[0] = 1'b1; power_data_in[0] = 32'h51; fb_ready_in = 1'b1;
    filtered_ready_in = 1'b1;
    #1;
    check("rst_pre_streaming", fb_valid_out, 1);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("rst_async_outputs", {power_ready_out, fb_valid_out, fb_last_out,
                                filtered_valid_out, fb_filtered_ready_out}, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_idle_after", fb_valid_out, 0);
    @(negedge clk_in);
    stream_frame(0, 3, 1'b1, 1'b0, 0, 1'b0, got, last_at, bad);
    check("rst_next_beats", got, 3);
    deliver_result(32'h500, 0, chan, bad);
    check("rst_next_chan", chan, 0);

    // ---------------- randomized contention vs frame-level model ----------
    // Both channels always have a backlog and only pause mid-frame, so the
    // expected service order is simply ch0 f0, ch1 f0, ch0 f1, ...
    do_reset();
    for (int f = 0; f < 6; f++)
      for (int c = 0; c < 2; c++) flen[c][f] = $urandom_range(1, 12);
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 2; c++) begin
        s = '0;
        for (int b = 0; b < flen[c][f]; b++) begin
          d = {8'(c), 8'(f), 16'(b)};
          exp_beats.push_back(d);
          exp_last.push_back(b == flen[c][f] - 1);
          s += d;
        end
        exp_chan.push_back(c);
        exp_sum.push_back(s);
      end
    end
    fi = '{0, 0}; bi = '{0, 0};
    results_seen = 0; res_pend = 0; res_delay = 0; acc = '0; res_val = '0;
    for (int cyc = 0; cyc < 20000 && results_seen < 12; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (fi[c] < 6) begin
          power_valid_in[c] = (bi[c] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          power_data_in[c]  = {8'(c), 8'(fi[c]), 16'(bi[c])};
          power_last_in[c]  = (bi[c] == flen[c][fi[c]] - 1);
        end else begin
          power_valid_in[c] = 1'b0;
          power_last_in[c]  = 1'b0;
        end
      end
      fb_ready_in       = ($urandom_range(0, 9) < 7);
      filtered_ready_in = 1'($urandom_range(0, 1));
      fb_filtered_valid_in = 1'b0;
      if (res_pend) begin
        if (res_delay > 0) res_delay--;
        else fb_filtered_valid_in = 1'b1;
        for (int i = 0; i < NF; i++) fb_filtered_data_in[i] = res_val + 32'(i);
      end
      #1;
      check("rand_ready_onehot", $countones(power_ready_out) <= 1, 1);
      for (int c = 0; c < 2; c++) begin
        if (power_valid_in[c] && power_ready_out[c]) begin
          bi[c]++;
          if (bi[c] == flen[c][fi[c]]) begin
            bi[c] = 0;
            fi[c]++;
          end
        end
      end
      if (fb_valid_out && fb_ready_in) begin
        if (exp_beats.size() == 0) begin
          check("rand_extra_beat", 1, 0);
        end else begin
          check("rand_beat_data", fb_data_out, exp_beats.pop_front());
          check("rand_beat_last", fb_last_out, exp_last.pop_front());
        end
        acc += fb_data_out;
        if (fb_last_out) begin
          res_pend  = 1'b1;
          res_delay = $urandom_range(0, 3);
          res_val   = acc;
          acc       = '0;
        end
      end
      if (fb_filtered_valid_in && fb_filtered_ready_out) res_pend = 1'b0;
      if (filtered_valid_out && filtered_ready_in) begin
        if (exp_chan.size() == 0) begin
          check("rand_extra_result", 1, 0);
        end else begin
          s = exp_sum.pop_front();
          check("rand_chan", filtered_chan_out, exp_chan.pop_front());
          check("rand_sum0", filtered_data_out[0], s);
          check("rand_sumN", filtered_data_out[NF-1], s + 32'(NF - 1));
        end
        results_seen++;
      end
      @(negedge clk_in);
    end
    check("rand_results_done", results_seen, 12);
    check("rand_beats_left", exp_beats.size(), 0);
    check("rand_overrun", overrun_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
